// File: rtl/ets_average_packer.sv
// ets_average_packer
// Snapshots the ETS core's sixteen accumulator sums and count on the rising
// edge of done. Each sum is optionally divided by the count with a restoring
// divider, and the sixteen results are streamed over valid/ready.
module ets_average_packer #(
  parameter bit AVERAGE = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         done,
  input  logic [511:0] sum_in,
  input  logic [31:0]  count_in,
  output logic [31:0]  m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_last,
  output logic         busy,
  output logic         err_zero
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVIDE  = 2'd1,
    S_SEND    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t      state;
  logic        done_q;
  logic        armed;
  logic [3:0]  index;
  logic [4:0]  bit_cnt;
  logic [31:0] rem;
  logic [31:0] quot;
  logic [31:0] shadow_div;
  logic [31:0] shadow_sum [16];

  logic        trigger;
  logic [31:0] cur_word;
  logic [31:0] next_word;
  logic [32:0] rem_shift;
  logic [32:0] rem_diff;
  logic        rem_fits;
  logic [31:0] rem_next;
  logic [31:0] quot_next;

  // A snapshot needs a fresh rising edge of done while idle and armed; armed
  // keeps a done that is already high when reset lifts from looking like an edge.
  assign trigger   = (state == S_IDLE) && armed && done && !done_q;
  assign cur_word  = shadow_sum[index];
  assign next_word = shadow_sum[index + 4'd1];

  // One restoring-division step: bring down the next dividend bit, subtract
  // the divisor when it fits, and shift the resulting quotient bit in.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path; a missing
    // default here would infer a latch.
    rem_shift = {rem, cur_word[bit_cnt]};
    rem_diff  = rem_shift - {1'b0, shadow_div};
    rem_fits  = (rem_shift >= {1'b0, shadow_div});
    rem_next  = rem_shift[31:0];
    if (rem_fits) begin
      rem_next = rem_diff[31:0];
    end
    quot_next = {quot[30:0], rem_fits};
  end

  // Shadow copy of the sums, taken only at the snapshot so the core can
  // restart its accumulators once busy is seen.
  // NOTE: this storage has no reset; it is always written before it is read.
  always_ff @(posedge clock) begin
    if (trigger) begin
      for (int i = 0; i < 16; i++) begin
        shadow_sum[i] <= sum_in[32*i +: 32];
      end
    end
  end

  // Control FSM with registered stream outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      done_q     <= 1'b0;
      armed      <= 1'b0;
      index      <= 4'd0;
      bit_cnt    <= 5'd0;
      rem        <= 32'd0;
      quot       <= 32'd0;
      shadow_div <= 32'd1;
      m_data     <= 32'd0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      busy       <= 1'b0;
      err_zero   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      done_q <= done;
      if (state == S_IDLE && !done) begin
        armed <= 1'b1;
      end
      unique case (state)
        S_IDLE: begin
          if (trigger) begin
            index      <= 4'd0;
            err_zero   <= (count_in == 32'd0);
            shadow_div <= (count_in == 32'd0) ? 32'd1 : count_in;
            busy       <= 1'b1;
            rem        <= 32'd0;
            quot       <= 32'd0;
            bit_cnt    <= 5'd31;
            if (AVERAGE) begin
              state <= S_DIVIDE;
            end else begin
              state   <= S_SEND;
              m_valid <= 1'b1;
              m_data  <= sum_in[31:0];
              m_last  <= 1'b0;
            end
          end
        end
        S_DIVIDE: begin
          rem     <= rem_next;
          quot    <= quot_next;
          bit_cnt <= bit_cnt - 5'd1;
          if (bit_cnt == 5'd0) begin
            state   <= S_SEND;
            m_valid <= 1'b1;
            m_data  <= quot_next;
            m_last  <= (index == 4'd15);
          end
        end
        S_SEND: begin
          if (m_ready) begin
            if (index == 4'd15) begin
              state   <= S_RELEASE;
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              busy    <= 1'b0;
            end else begin
              index <= index + 4'd1;
              if (AVERAGE) begin
                state   <= S_DIVIDE;
                m_valid <= 1'b0;
                m_last  <= 1'b0;
                rem     <= 32'd0;
                quot    <= 32'd0;
                bit_cnt <= 5'd31;
              end else begin
                m_data <= next_word;
                m_last <= (index == 4'd14);
              end
            end
          end
        end
        S_RELEASE: begin
          if (!done) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ets_average_packer.sv
// Directed bench for ets_average_packer: one averaging instance and one
// raw-stream instance share clock, reset, sums, count and m_ready.
module tb_ets_average_packer;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         done_a = 1'b0;
  logic         done_r = 1'b0;
  logic [511:0] sum_in = '0;
  logic [31:0]  count_in = 32'd0;
  logic         m_ready = 1'b0;

  logic [31:0]  m_data_a, m_data_r;
  logic         m_valid_a, m_valid_r;
  logic         m_last_a, m_last_r;
  logic         busy_a, busy_r;
  logic         err_zero_a, err_zero_r;

  int n_cmp = 0;
  int n_bad = 0;

  // Results of the most recent collect() call.
  logic [31:0] got_data [16];
  logic        got_last [16];
  int          got_n;
  int          stall_bad;
  int          busy_early;
  logic        busy_after;
  logic [31:0] exp_data [16];

  ets_average_packer #(.AVERAGE(1'b1)) dut_avg (
    .clock(clock), .reset(reset), .done(done_a), .sum_in(sum_in),
    .count_in(count_in), .m_data(m_data_a), .m_valid(m_valid_a),
    .m_ready(m_ready), .m_last(m_last_a), .busy(busy_a), .err_zero(err_zero_a)
  );

  ets_average_packer #(.AVERAGE(1'b0)) dut_raw (
    .clock(clock), .reset(reset), .done(done_r), .sum_in(sum_in),
    .count_in(count_in), .m_data(m_data_r), .m_valid(m_valid_r),
    .m_ready(m_ready), .m_last(m_last_r), .busy(busy_r), .err_zero(err_zero_r)
  );

  always #5 clock = ~clock;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_sums(input logic [31:0] base, input logic [31:0] step);
    for (int i = 0; i < 16; i++) begin
      sum_in[32*i +: 32] = base + step * i;
    end
  endtask

  // Gathers up to 16 handshaken words from one instance, tracking stability
  // of stalled words and any early drop of busy. sel_avg=1 picks dut_avg.
  task automatic collect(input bit sel_avg, input bit rand_ready, input int budget);
    logic        v, l, b, stalled;
    logic [31:0] d, held_d;
    logic        held_l;
    got_n = 0; stall_bad = 0; busy_early = 0; stalled = 1'b0;
    held_d = '0; held_l = 1'b0;
    for (int cyc = 0; cyc < budget && got_n < 16; cyc++) begin
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      v = sel_avg ? m_valid_a : m_valid_r;
      d = sel_avg ? m_data_a  : m_data_r;
      l = sel_avg ? m_last_a  : m_last_r;
      b = sel_avg ? busy_a    : busy_r;
      if (stalled && (!v || d !== held_d || l !== held_l)) stall_bad++;
      if (!b) busy_early++;
      if (v && m_ready) begin
        got_data[got_n] = d;
        got_last[got_n] = l;
        got_n++;
        stalled = 1'b0;
      end else if (v) begin
        stalled = 1'b1; held_d = d; held_l = l;
      end else begin
        stalled = 1'b0;
      end
      tick();
    end
    busy_after = sel_avg ? busy_a : busy_r;
  endtask

  task automatic test_reset();
    done_a = 1'b1;
    done_r = 1'b1;
    reset = 1'b1;
    tick(2);
    n_cmp++; if ({m_valid_a, m_last_a, busy_a, err_zero_a} !== 4'b0 || m_data_a !== 32'd0) begin
      n_bad++; $display("FAIL reset_avg_outputs: got v%b l%b b%b e%b d=%h, want all 0", m_valid_a, m_last_a, busy_a, err_zero_a, m_data_a);
    end
    n_cmp++; if ({m_valid_r, m_last_r, busy_r, err_zero_r} !== 4'b0 || m_data_r !== 32'd0) begin
      n_bad++; $display("FAIL reset_raw_outputs: got v%b l%b b%b e%b d=%h, want all 0", m_valid_r, m_last_r, busy_r, err_zero_r, m_data_r);
    end
    // done stays high through reset release: must not count as an edge.
    reset = 1'b0;
    tick(4);
    n_cmp++; if (busy_a !== 1'b0 || busy_r !== 1'b0) begin
      n_bad++; $display("FAIL reset_no_trigger_done_high: busy_a=%b busy_r=%b, want 0 0", busy_a, busy_r);
    end
    done_a = 1'b0;
    done_r = 1'b0;
    tick(2);
  endtask

  task automatic test_average();
    count_in = 32'd4;
    set_sums(32'd7, 32'd4);  // word i = 4*(i+1)+3 -> average i+1
    m_ready = 1'b1;
    done_a = 1'b1;
    tick();       // E0
    tick(31);     // E31
    n_cmp++; if (m_valid_a !== 1'b0 || busy_a !== 1'b1) begin
      n_bad++; $display("FAIL avg_latency_before: after E31 valid=%b busy=%b, want 0 1", m_valid_a, busy_a);
    end
    tick();       // E32
    n_cmp++; if (m_valid_a !== 1'b1 || m_data_a !== 32'd1) begin
      n_bad++; $display("FAIL avg_latency_first: after E32 valid=%b data=%0d, want 1 1", m_valid_a, m_data_a);
    end
    collect(1'b1, 1'b0, 1200);
    n_cmp++; if (got_n !== 16) begin
      n_bad++; $display("FAIL avg_word_count: got %0d words, want 16", got_n);
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (got_data[i] !== 32'(i + 1) || got_last[i] !== (i == 15)) begin
        n_bad++; $display("FAIL avg_word[%0d]: data=%0d last=%b, want %0d %b", i, got_data[i], got_last[i], i + 1, (i == 15));
      end
    end
    n_cmp++; if (busy_after !== 1'b0 || err_zero_a !== 1'b0) begin
      n_bad++; $display("FAIL avg_end_flags: busy=%b err_zero=%b, want 0 0", busy_after, err_zero_a);
    end
    done_a = 1'b0;
    tick(2);
  endtask

  task automatic test_back_to_back();
    count_in = 32'd1000;
    set_sums(32'hFFFF_FFF0, 32'd1);
    m_ready = 1'b1;
    done_r = 1'b1;
    tick();       // E0
    n_cmp++; if (m_valid_r !== 1'b1 || busy_r !== 1'b1) begin
      n_bad++; $display("FAIL raw_first_valid: valid=%b busy=%b, want 1 1", m_valid_r, busy_r);
    end
    collect(1'b0, 1'b0, 16);
    n_cmp++; if (got_n !== 16) begin
      n_bad++; $display("FAIL raw_16_cycles: got %0d words in 16 cycles, want 16", got_n);
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (got_data[i] !== 32'hFFFF_FFF0 + 32'(i) || got_last[i] !== (i == 15)) begin
        n_bad++; $display("FAIL raw_word[%0d]: data=%h last=%b, want %h %b", i, got_data[i], got_last[i], 32'hFFFF_FFF0 + 32'(i), (i == 15));
      end
    end
    n_cmp++; if (busy_after !== 1'b0 || err_zero_r !== 1'b0 || m_valid_r !== 1'b0) begin
      n_bad++; $display("FAIL raw_end_flags: busy=%b err_zero=%b valid=%b, want 0 0 0", busy_after, err_zero_r, m_valid_r);
    end
    done_r = 1'b0;
    tick(2);
  endtask

  task automatic test_zero_count();
    count_in = 32'd0;
    set_sums(32'h100, 32'd0);
    m_ready = 1'b1;
    done_a = 1'b1;
    tick();
    n_cmp++; if (err_zero_a !== 1'b1) begin
      n_bad++; $display("FAIL zero_err_set: err_zero=%b, want 1", err_zero_a);
    end
    collect(1'b1, 1'b0, 1200);
    n_cmp++; if (got_n !== 16) begin
      n_bad++; $display("FAIL zero_word_count: got %0d words, want 16", got_n);
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (got_data[i] !== 32'h100) begin
        n_bad++; $display("FAIL zero_word[%0d]: data=%h, want 00000100", i, got_data[i]);
      end
    end
    done_a = 1'b0;
    tick(3);
    n_cmp++; if (err_zero_a !== 1'b1) begin
      n_bad++; $display("FAIL zero_err_sticky: err_zero=%b, want 1", err_zero_a);
    end
  endtask

  task automatic test_backpressure();
    // Averaging instance: word i = 100*i + 7, count 3.
    count_in = 32'd3;
    set_sums(32'd7, 32'd100);
    for (int i = 0; i < 16; i++) exp_data[i] = (32'd100 * 32'(i) + 32'd7) / 32'd3;
    m_ready = 1'b0;
    done_a = 1'b1;
    tick();
    n_cmp++; if (err_zero_a !== 1'b0) begin
      n_bad++; $display("FAIL bp_err_cleared: err_zero=%b, want 0", err_zero_a);
    end
    collect(1'b1, 1'b1, 2500);
    n_cmp++; if (got_n !== 16 || stall_bad !== 0 || busy_early !== 0 || busy_after !== 1'b0) begin
      n_bad++; $display("FAIL bp_avg_stream: words=%0d unstable=%0d early_idle=%0d busy_end=%b, want 16 0 0 0", got_n, stall_bad, busy_early, busy_after);
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (got_data[i] !== exp_data[i] || got_last[i] !== (i == 15)) begin
        n_bad++; $display("FAIL bp_avg_word[%0d]: data=%0d last=%b, want %0d %b", i, got_data[i], got_last[i], exp_data[i], (i == 15));
      end
    end
    done_a = 1'b0;
    // Raw instance: every word in the SEND state, so stalls hit more often.
    set_sums(32'hA5A5_0000, 32'h11);
    m_ready = 1'b0;
    done_r = 1'b1;
    tick();
    collect(1'b0, 1'b1, 400);
    n_cmp++; if (got_n !== 16 || stall_bad !== 0 || busy_early !== 0 || busy_after !== 1'b0) begin
      n_bad++; $display("FAIL bp_raw_stream: words=%0d unstable=%0d early_idle=%0d busy_end=%b, want 16 0 0 0", got_n, stall_bad, busy_early, busy_after);
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (got_data[i] !== 32'hA5A5_0000 + 32'h11 * 32'(i) || got_last[i] !== (i == 15)) begin
        n_bad++; $display("FAIL bp_raw_word[%0d]: data=%h last=%b, want %h %b", i, got_data[i], got_last[i], 32'hA5A5_0000 + 32'h11 * 32'(i), (i == 15));
      end
    end
    done_r = 1'b0;
    tick(2);
  endtask

  task automatic test_retrigger();
    count_in = 32'd5;
    set_sums(32'h1000, 32'd1);
    m_ready = 1'b0;
    done_r = 1'b1;
    tick();                       // snapshot of the first frame
    done_r = 1'b0;
    tick();
    count_in = 32'd0;
    set_sums(32'hDEAD_0000, 32'd1);
    done_r = 1'b1; tick();
    done_r = 1'b0; tick();
    done_r = 1'b1; tick();
    n_cmp++; if (m_valid_r !== 1'b1 || m_data_r !== 32'h1000 || err_zero_r !== 1'b0) begin
      n_bad++; $display("FAIL retrig_ignored: valid=%b data=%h err_zero=%b, want 1 00001000 0", m_valid_r, m_data_r, err_zero_r);
    end
    collect(1'b0, 1'b0, 40);
    n_cmp++; if (got_n !== 16 || got_data[9] !== 32'h1009 || got_data[15] !== 32'h100F) begin
      n_bad++; $display("FAIL retrig_first_frame: words=%0d w9=%h w15=%h, want 16 00001009 0000100f", got_n, got_data[9], got_data[15]);
    end
    tick(5);                      // done still high
    n_cmp++; if (busy_r !== 1'b0 || m_valid_r !== 1'b0) begin
      n_bad++; $display("FAIL retrig_held_done: busy=%b valid=%b, want 0 0", busy_r, m_valid_r);
    end
    done_r = 1'b0;
    tick(2);
    done_r = 1'b1;
    tick();
    n_cmp++; if (busy_r !== 1'b1 || m_data_r !== 32'hDEAD_0000 || err_zero_r !== 1'b1) begin
      n_bad++; $display("FAIL retrig_new_edge: busy=%b data=%h err_zero=%b, want 1 dead0000 1", busy_r, m_data_r, err_zero_r);
    end
    collect(1'b0, 1'b0, 40);
    n_cmp++; if (got_n !== 16 || got_data[15] !== 32'hDEAD_000F || got_last[15] !== 1'b1) begin
      n_bad++; $display("FAIL retrig_second_frame: words=%0d w15=%h last=%b, want 16 dead000f 1", got_n, got_data[15], got_last[15]);
    end
    done_r = 1'b0;
    tick(2);
  endtask

  task automatic test_reset_mid_frame();
    count_in = 32'd7;
    set_sums(32'h3000_0000, 32'd1);
    m_ready = 1'b1;
    done_r = 1'b1;
    tick();                       // E0: word 0 shown
    tick(7);                      // words 0..6 accepted
    m_ready = 1'b0;
    n_cmp++; if (m_valid_r !== 1'b1 || m_data_r !== 32'h3000_0007 || m_last_r !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_word7: valid=%b data=%h last=%b, want 1 30000007 0", m_valid_r, m_data_r, m_last_r);
    end
    reset = 1'b1;
    tick();
    n_cmp++; if (m_valid_r !== 1'b0 || busy_r !== 1'b0 || m_data_r !== 32'd0) begin
      n_bad++; $display("FAIL rst_mid_cleared: valid=%b busy=%b data=%h, want 0 0 00000000", m_valid_r, busy_r, m_data_r);
    end
    reset = 1'b0;
    tick(3);                      // done still high after reset
    n_cmp++; if (busy_r !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_no_retrigger: busy=%b, want 0", busy_r);
    end
    done_r = 1'b0;
    tick(2);
    done_r = 1'b1;
    tick();
    collect(1'b0, 1'b0, 20);
    n_cmp++; if (got_n !== 16 || got_data[0] !== 32'h3000_0000 || got_data[15] !== 32'h3000_000F) begin
      n_bad++; $display("FAIL rst_mid_restart: words=%0d w0=%h w15=%h, want 16 30000000 3000000f", got_n, got_data[0], got_data[15]);
    end
    done_r = 1'b0;
    tick(2);
  endtask

  initial begin
    tick();
    test_reset();
    test_average();
    test_back_to_back();
    test_zero_count();
    test_backpressure();
    test_retrigger();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
